// File: rtl/yarp_data_mem_resp.sv
// YARP data-memory responder: word storage with byte-lane stores, same-cycle loads, error pulse and counters.
// Optional MMIO window (cycle/store/error counters) is enabled by defining YARP_DMEM_MMIO_EN.
module yarp_data_mem_resp #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter logic [31:0] MMIO_ADDR = 32'h0002_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_mem_req_i,
    input  logic [31:0] data_mem_addr_i,
    input  logic [1:0]  data_mem_byte_en_i,
    input  logic        data_mem_wr_i,
    input  logic [31:0] data_mem_wr_data_i,
    output logic [31:0] data_mem_rd_data_o,
    output logic        data_mem_err_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    logic [31:0]   mem [DEPTH];

    logic [31:0]   base_off;
    logic          hit;
    logic          misaligned;
    logic          req_err;
    logic          store_en;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [3:0]    lane_mask;
    logic [31:0]   wr_shift;

    logic [31:0]   cyc_cnt;
    logic [31:0]   st_cnt;
    logic [31:0]   err_cnt;

`ifdef YARP_DMEM_MMIO_EN
    logic [31:0]   mmio_off;
    logic          mmio_ok;
    logic          mmio_clr;
`endif

    always_comb begin
        // offset compare handles any BASE_ADDR without relying on upper-bit equality
        base_off = data_mem_addr_i - BASE_ADDR;
        hit      = (base_off < SPAN);
        idx      = data_mem_addr_i[AW+1:2];
        lane     = data_mem_addr_i[1:0];

        case (data_mem_byte_en_i)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = data_mem_addr_i[0];
            2'b11:   misaligned = |data_mem_addr_i[1:0];
            default: misaligned = 1'b1;
        endcase

        case (data_mem_byte_en_i)
            2'b00:   lane_mask = 4'b0001 << lane;
            2'b01:   lane_mask = 4'b0011 << lane;
            default: lane_mask = 4'b1111;
        endcase

        wr_shift = data_mem_wr_data_i << {lane, 3'b000};
        store_en = data_mem_req_i & data_mem_wr_i & ~misaligned & hit;

`ifdef YARP_DMEM_MMIO_EN
        mmio_off = data_mem_addr_i - MMIO_ADDR;
        mmio_ok  = (mmio_off < 32'd12) && (data_mem_byte_en_i == 2'b11) && !misaligned;
        mmio_clr = data_mem_req_i & data_mem_wr_i & mmio_ok & (mmio_off[3:2] == 2'b10);
        req_err  = data_mem_req_i & (misaligned | (~hit & ~mmio_ok));
`else
        req_err  = data_mem_req_i & (misaligned | ~hit);
`endif

        data_mem_rd_data_o = '0;
        if (data_mem_req_i && !data_mem_wr_i && !misaligned) begin
            if (hit) begin
                data_mem_rd_data_o = mem[idx];
            end
`ifdef YARP_DMEM_MMIO_EN
            else if (mmio_ok) begin
                case (mmio_off[3:2])
                    2'b00:   data_mem_rd_data_o = cyc_cnt;
                    2'b01:   data_mem_rd_data_o = st_cnt;
                    default: data_mem_rd_data_o = err_cnt;
                endcase
            end
`endif
        end
    end

    // storage is deliberately not reset; stores are suppressed while reset is high
    always_ff @(posedge clk) begin
        if (!reset && store_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (lane_mask[b]) begin
                    mem[idx][8*b +: 8] <= wr_shift[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_mem_err_o <= 1'b0;
            cyc_cnt        <= '0;
            st_cnt         <= '0;
            err_cnt        <= '0;
        end else begin
            data_mem_err_o <= req_err;
            cyc_cnt        <= cyc_cnt + 32'd1;
            if (store_en) begin
                st_cnt <= st_cnt + 32'd1;
            end
`ifdef YARP_DMEM_MMIO_EN
            if (mmio_clr) begin
                err_cnt <= '0;
            end else
`endif
            if (data_mem_err_o) begin
                err_cnt <= err_cnt + 32'd1;
            end
        end
    end

endmodule

// File: doc/yarp_data_mem_resp.md
# yarp_data_mem_resp

Data-memory responder for the YARP core: the memory-side end of the core's data memory interface. It accepts the core's request, address, size, write-enable and write data, and holds a word-organised storage array. Reads return the addressed word in the same cycle; stores are committed at the clock edge with per-lane byte enables. Size-misaligned accesses and out-of-range accesses are detected and counted. An optional MMIO window exposes a cycle counter and access statistics.

## Interface
- DEPTH, 1024, storage size in 32-bit words; power of two, ≥ 4.
- BASE_ADDR, 32'h0001_0000, byte address of word 0; aligned to DEPTH*4.
- MMIO_ADDR, 32'h0002_0000, byte address of the MMIO window (3 words); must not overlap storage.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_mem_req_i  in  1  access request, valid for one cycle per access.
- data_mem_addr_i  in  32  byte address.
- data_mem_byte_en_i  in  2  size encoding: 2'b00 = byte, 2'b01 = half, 2'b11 = word; 2'b10 is illegal.
- data_mem_wr_i  in  1  1 = store, 0 = load; qualified by req.
- data_mem_wr_data_i  in  32  store data, right-justified in the low bits.
- data_mem_rd_data_o  out  32  load data (raw aligned word); combinational.
- data_mem_err_o  out  1  one-cycle pulse, registered, on a misaligned, illegal or out-of-range access.

## Operation
- Address decode:
  - Storage hit: BASE_ADDR ≤ addr < BASE_ADDR + DEPTH*4.
  - Word index is addr[log2(DEPTH)+1:2]; lane is addr[1:0].
- Misaligned access is any of:
  - half with addr[0] = 1;
  - word with addr[1:0] ≠ 0;
  - size 2'b10.
- Load (req & !wr):
  - rd_data_o = full stored word at the word index, no lane shift. The core extracts and extends.
  - Misses and misaligned loads return 32'h0.
  - When req = 0, rd_data_o = 32'h0.
- Store (req & wr & aligned & hit): wr_data is shifted left by 8*lane and written under the lane mask.
  - Byte: lane only.
  - Half: lanes {lane+1, lane}.
  - Word: all four lanes.
  - Unmasked bytes are preserved.
- Dropped stores: misaligned or out-of-range stores do not modify storage.
- Error flag: err_o is set on the next edge after any misaligned, illegal or out-of-range request.
- Counters (32-bit, wrap to 0 after 32'hFFFF_FFFF):
  - cyc_cnt increments every cycle out of reset.
  - st_cnt increments per committed store.
  - err_cnt increments per err_o pulse.
- Storage contents are not affected by reset. Simulation initial value is X.

## Timing
- Load: zero-cycle latency. rd_data_o is valid in the request cycle, so the core completes the load in a single cycle.
- Store: committed at the rising edge ending the request cycle. A load of the same address in the next cycle returns the new data.
- Same-cycle store and load cannot occur: there is one request per cycle.
- err_o: asserted exactly one cycle after the offending request cycle, for one cycle. Back-to-back errors give a continuous high.
- Reset: while reset = 1, on each edge:
  - err_o ← 0, cyc_cnt ← 0, st_cnt ← 0, err_cnt ← 0;
  - in-flight stores in that cycle are dropped.
- Counter reads: return the pre-edge value. A load of st_cnt in the cycle of a store sees the old count.

## Configuration
- YARP_DMEM_MMIO_EN defined:
  - Loads at MMIO_ADDR, +4 and +8 return cyc_cnt, st_cnt and err_cnt respectively.
  - A word store to MMIO_ADDR+8 clears err_cnt to 0. Clear wins over a simultaneous increment.
  - Stores to the other MMIO words are ignored without error.
  - Non-word or misaligned MMIO accesses are errors.
- YARP_DMEM_MMIO_EN undefined:
  - MMIO addresses decode as out-of-range: loads return 0 and raise err_o.
  - Counters are still maintained internally but are not observable.

## Test plan
- Word store 32'hDEAD_BEEF to BASE_ADDR+8, then word load of the same address → rd_data_o = 32'hDEAD_BEEF; err_o stays 0.
- Word store 32'h1122_3344 to BASE_ADDR, then byte store 8'hAA to BASE_ADDR+2 and half store 16'h5566 to BASE_ADDR+0 → load returns 32'h11AA_5566.
- Half store to BASE_ADDR+1 → storage unchanged; err_o = 1 for exactly one cycle the next cycle; err_cnt = 1.
- Load of BASE_ADDR + DEPTH*4 → rd_data_o = 0 and err_o pulses. Store to the same address → no storage change.
- With the macro, 3 stores then a load of MMIO_ADDR+4 → 3. Word store to MMIO_ADDR+8 in the same cycle as an error → err_cnt reads 0 next cycle. Without the macro, a load of MMIO_ADDR returns 0 and err_o pulses.
- Assert reset for 1 cycle mid-sequence with a store in flight → store dropped; err_o = 0; cyc_cnt reads 1 one cycle after release; prior storage data retained.
